// File: rtl/bus_rr_arbiter4_pkg.sv
// Shared types and constants for the four-source round-robin bus arbiter.
package bus_arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = {NREQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter4_if.sv
// Request/grant bundle between the arbiter (master) and the bus sources (slave).
interface bus_rr_arbiter4_if;
  import bus_arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] sel;
  logic             bus_en;
  logic             busy;

  modport master (input req, output gnt, output sel, output bus_en, output busy);
  modport slave  (output req, input gnt, input sel, input bus_en, input busy);

endinterface

// File: rtl/bus_rr_arbiter4_rr_pick4.sv
// Combinational rotating-priority picker: first set req bit at or after start, modulo 4.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand_s;
  logic             valid_s;
  logic [IDX_W-1:0] idx_s;

  // Scan from the farthest offset back to start so the nearest requester wins last.
  always_comb begin
    valid_s = 1'b0;
    idx_s   = start;
    cand_s  = start;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_s  = start + IDX_W'(i);
      valid_s = valid_s | req[cand_s];
      idx_s   = req[cand_s] ? cand_s : idx_s;
    end
  end

  assign valid = valid_s;
  assign idx   = idx_s;

endmodule

// File: rtl/bus_rr_arbiter4.sv
// Round-robin owner sequencer for a four-driver tristate bus, with one idle
// turnaround cycle between owners so no two drivers ever overlap.
module bus_rr_arbiter4
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
)
(
  input  logic               clk,
  input  logic               rst_n,
  bus_rr_arbiter4_if.master  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] ptr_nxt_s;
  logic [IDX_W-1:0] sel_r;
  logic [IDX_W-1:0] sel_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [NREQ-1:0]  gnt_r;
  logic             bus_en_r;
  logic             busy_r;

  logic [IDX_W-1:0] start_s;
  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;

  // TURN searches from just past the outgoing owner so it drops to last priority.
  assign start_s = (state_r == ST_TURN) ? (sel_r + 2'd1) : ptr_r;

  rr_pick4 u_pick (
    .req   (bus.req),
    .start (start_s),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Next-state, pointer, owner and hold-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    sel_nxt_s   = sel_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          sel_nxt_s   = pick_idx_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        if (!bus.req[sel_r] || (cnt_r == HOLD_LAST)) begin
          state_nxt_s = ST_TURN;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_TURN: begin
        ptr_nxt_s = sel_r + 2'd1;
        if (pick_valid_s) begin
          sel_nxt_s   = pick_idx_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State registers; outputs are registered from the next state so reset floats the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ptr_r    <= {IDX_W{1'b0}};
      sel_r    <= {IDX_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      gnt_r    <= {NREQ{1'b0}};
      bus_en_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      sel_r    <= sel_nxt_s;
      cnt_r    <= cnt_nxt_s;
      gnt_r    <= (state_nxt_s == ST_GRANT) ? idx_to_onehot(sel_nxt_s) : {NREQ{1'b0}};
      bus_en_r <= (state_nxt_s == ST_GRANT);
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.sel    = sel_r;
  assign bus.bus_en = bus_en_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_bus_rr_arbiter4.sv
// Scoreboard bench: stimulus queues expected grant runs (owner, length, gap);
// a negedge monitor rebuilds runs from gnt, compares them and checks invariants.
module tb_bus_rr_arbiter4;

  typedef struct {
    int owner;
    int len;
    int gap;
  } run_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  run_t exp_q0[$];
  run_t exp_q1[$];
  logic [3:0] prev_g[3];
  int run_len[3];
  int gap_cnt[3];
  int run_gap[3];
  bit sb_on[3];

  bus_rr_arbiter4_if if4 ();
  bus_rr_arbiter4_if if1 ();
  bus_rr_arbiter4_if if7 ();

  bus_rr_arbiter4 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  bus_rr_arbiter4 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bus_rr_arbiter4 #(.MAX_HOLD(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(if7));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int oh2idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = i;
    end
    return r;
  endfunction

  task automatic push_exp(input int id, input int owner, input int len, input int gap);
    run_t e;
    e.owner = owner;
    e.len   = len;
    e.gap   = gap;
    if (id == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic end_run(input int id, input int owner, input int len, input int gap);
    run_t e;
    bit   have;
    have = 1'b0;
    if (sb_on[id]) begin
      if (id == 0 && exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        have = 1'b1;
      end else if (id == 1 && exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        have = 1'b1;
      end
      n_tests++;
      if (!have) begin
        n_fail++;
        $display("FAIL run_dut%0d: unexpected run owner=%0d len=%0d gap=%0d", id, owner, len, gap);
      end else if (e.owner != owner || e.len != len || (e.gap >= 0 && e.gap != gap)) begin
        n_fail++;
        $display("FAIL run_dut%0d: got owner=%0d len=%0d gap=%0d, required owner=%0d len=%0d gap=%0d",
                 id, owner, len, gap, e.owner, e.len, e.gap);
      end
    end
  endtask

  task automatic mon_step(input int id, input logic [3:0] g, input logic [1:0] s,
                          input logic en, input logic bz, input int maxh);
    bit ok;
    if (!rst_n) begin
      prev_g[id]  = 4'b0000;
      run_len[id] = 0;
      gap_cnt[id] = 0;
    end else begin
      if (prev_g[id] != 4'b0000 && g != prev_g[id]) begin
        end_run(id, oh2idx(prev_g[id]), run_len[id], run_gap[id]);
        gap_cnt[id] = 0;
      end
      if (g != 4'b0000) begin
        if (g != prev_g[id]) begin
          run_len[id] = 1;
          run_gap[id] = gap_cnt[id];
        end else begin
          run_len[id]++;
        end
      end else begin
        gap_cnt[id]++;
      end
      ok = ((g & (g - 4'd1)) == 4'd0)
        && (en === (|g))
        && (!en || g == (4'b0001 << s))
        && (prev_g[id] == 4'b0000 || g == 4'b0000 || g == prev_g[id])
        && (g == 4'b0000 || run_len[id] <= maxh)
        && (!(prev_g[id] != 4'b0000 && g == 4'b0000) || bz)
        && (!en || bz);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL inv_dut%0d: gnt=%b prev=%b sel=%0d bus_en=%b busy=%b run_len=%0d max=%0d",
                 id, g, prev_g[id], s, en, bz, run_len[id], maxh);
      end
      prev_g[id] = g;
    end
  endtask

  // Monitor: one process for all three instances keeps the counters race-free.
  always @(negedge clk) begin
    mon_step(0, if4.gnt, if4.sel, if4.bus_en, if4.busy, 4);
    mon_step(1, if1.gnt, if1.sel, if1.bus_en, if1.busy, 1);
    mon_step(2, if7.gnt, if7.sel, if7.bus_en, if7.busy, 7);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] r;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 3; i++) begin
      prev_g[i]  = 4'b0000;
      run_len[i] = 0;
      gap_cnt[i] = 0;
      run_gap[i] = 0;
    end
    sb_on[0] = 1'b1;
    sb_on[1] = 1'b1;
    sb_on[2] = 1'b0;
    rst_n   = 1'b0;
    if4.req = 4'b0000;
    if1.req = 4'b0000;
    if7.req = 4'b0000;
    repeat (2) @(posedge clk);
    #2;
    check("reset_gnt", 32'(if4.gnt), 32'h0);
    check("reset_sel", 32'(if4.sel), 32'h0);
    check("reset_bus_en", 32'(if4.bus_en), 32'h0);
    check("reset_busy", 32'(if4.busy), 32'h0);

    // All four requesting from reset: owners 0,1,2,3,0, four cycles each.
    push_exp(0, 0, 4, -1);
    push_exp(0, 1, 4, 1);
    push_exp(0, 2, 4, 1);
    push_exp(0, 3, 4, 1);
    push_exp(0, 0, 4, 1);
    if4.req = 4'b1111;
    rst_n   = 1'b1;
    repeat (24) tick();
    if4.req = 4'b0000;
    repeat (4) tick();

    // Single source held for 12 sampled cycles.
    push_exp(0, 0, 4, -1);
    push_exp(0, 0, 4, 1);
    push_exp(0, 0, 2, 1);
    if4.req = 4'b0001;
    repeat (12) tick();
    if4.req = 4'b0000;
    repeat (4) tick();

    // Early release of source 1, then pointer wrap from owner 3 to 0 before 2.
    push_exp(0, 1, 3, -1);
    push_exp(0, 3, 2, 1);
    push_exp(0, 0, 4, 1);
    push_exp(0, 2, 4, 1);
    if4.req = 4'b1010;
    repeat (3) tick();
    if4.req = 4'b1000;
    repeat (2) tick();
    if4.req = 4'b1101;
    tick();
    if4.req = 4'b0101;
    repeat (11) tick();
    if4.req = 4'b0000;
    repeat (4) tick();

    // Reset in the middle of a grant to source 2.
    push_exp(0, 2, 1, -1);
    if4.req = 4'b0100;
    tick();
    check("pre_rst_gnt", 32'(if4.gnt), 32'h4);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(if4.gnt), 32'h0);
    check("async_rst_bus_en", 32'(if4.bus_en), 32'h0);
    check("async_rst_sel", 32'(if4.sel), 32'h0);
    check("async_rst_busy", 32'(if4.busy), 32'h0);
    tick();
    rst_n = 1'b1;
    check("post_rst_idle_gnt", 32'(if4.gnt), 32'h0);
    tick();
    check("post_rst_gnt", 32'(if4.gnt), 32'h4);
    check("post_rst_sel", 32'(if4.sel), 32'h2);
    check("post_rst_bus_en", 32'(if4.bus_en), 32'h1);
    if4.req = 4'b0000;
    repeat (4) tick();

    // MAX_HOLD=1 persistent single requester alternates grant and turnaround.
    push_exp(1, 0, 1, -1);
    push_exp(1, 0, 1, 1);
    push_exp(1, 0, 1, 1);
    push_exp(1, 0, 1, 1);
    if1.req = 4'b0001;
    repeat (8) tick();
    if1.req = 4'b0000;
    repeat (3) tick();

    // Random sweep on MAX_HOLD=1 and MAX_HOLD=7; invariants only.
    sb_on[1] = 1'b0;
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if1.req = r;
      if7.req = r;
      tick();
    end
    if1.req = 4'b0000;
    if7.req = 4'b0000;
    repeat (4) tick();

    check("sb0_drained", 32'(exp_q0.size()), 32'h0);
    check("sb1_drained", 32'(exp_q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
